// File: rtl/man_drawer.sv
// Sprite redraw engine: optionally erases the sprite at its previous row, then draws it at the
// newly captured row, emitting one registered VGA pixel write per cycle.
module man_drawer #(
    parameter logic [7:0]  X_POS        = 8'd20,
    parameter int unsigned SPR_W        = 8,
    parameter int unsigned SPR_H        = 12,
    parameter logic [2:0]  MAN_COLOUR   = 3'b111,
    parameter logic [2:0]  GHOST_COLOUR = 3'b011,
    parameter logic [2:0]  BG_COLOUR    = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       update,
    input  logic [6:0] y,
    input  logic       man_style,
    output logic       plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPR_H - 1);
    localparam logic [7:0]    ROW_MAX  = 8'd119;
    localparam logic [6:0]    OLD_Y_RST = 7'd108;

    typedef enum logic [1:0] {StIdle, StErase, StDraw, StFin} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [6:0]    y_cap_q, y_cap_d;
    logic          style_q, style_d;
    logic [6:0]    old_y_q, old_y_d;
    logic          old_valid_q, old_valid_d;
    logic          pending_q, pending_d;
    logic          last_pix;

    logic       plot_d, busy_d, frame_done_d;
    logic [7:0] vga_x_d;
    logic [6:0] vga_y_d;
    logic [2:0] colour_d;
    logic [6:0] base;
    logic [7:0] row_sum;

    assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            y_cap_q     <= '0;
            style_q     <= 1'b0;
            old_y_q     <= OLD_Y_RST;
            old_valid_q <= 1'b0;
            pending_q   <= 1'b0;
            plot        <= 1'b0;
            vga_x       <= '0;
            vga_y       <= '0;
            colour      <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            y_cap_q     <= y_cap_d;
            style_q     <= style_d;
            old_y_q     <= old_y_d;
            old_valid_q <= old_valid_d;
            pending_q   <= pending_d;
            plot        <= plot_d;
            vga_x       <= vga_x_d;
            vga_y       <= vga_y_d;
            colour      <= colour_d;
            busy        <= busy_d;
            frame_done  <= frame_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        y_cap_d     = y_cap_q;
        style_d     = style_q;
        old_y_d     = old_y_q;
        old_valid_d = old_valid_q;
        pending_d   = pending_q;
        unique case (state_q)
            StIdle: begin
                if (update || pending_q) begin
                    y_cap_d   = y;
                    style_d   = man_style;
                    pending_d = 1'b0;
                    row_d     = '0;
                    col_d     = '0;
                    state_d   = (old_valid_q && (y != old_y_q)) ? StErase : StDraw;
                end
            end
            StErase, StDraw: begin
                pending_d = pending_q | update;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                if (last_pix) begin
                    state_d = (state_q == StErase) ? StDraw : StFin;
                end
            end
            StFin: begin
                pending_d   = pending_q | update;
                old_y_d     = y_cap_q;
                old_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Pixel registers are loaded from next-state values so a pixel appears in the same cycle
    // as the state/counter that describes it.
    always_comb begin
        plot_d       = 1'b0;
        vga_x_d      = '0;
        vga_y_d      = '0;
        colour_d     = '0;
        base         = (state_d == StErase) ? old_y_q : y_cap_d;
        row_sum      = {1'b0, base} + 8'(row_d);
        busy_d       = (state_d != StIdle);
        frame_done_d = (state_d == StFin);
        if (state_d == StErase || state_d == StDraw) begin
            plot_d   = (row_sum <= ROW_MAX);
            vga_x_d  = X_POS + 8'(col_d);
            vga_y_d  = row_sum[6:0];
            colour_d = (state_d == StErase) ? BG_COLOUR :
                       (style_d ? MAN_COLOUR : GHOST_COLOUR);
        end
    end

endmodule

// File: doc/man_drawer.md
MAN_DRAWER -- requirements
Module: man_drawer

Interface
REQ-001 Parameter X_POS, default 8'd20, is the fixed screen column of the sprite's left edge.
REQ-002 Parameter SPR_W, default 8, is the sprite width in pixels; SPR_H, default 12, is the sprite height in pixels.
REQ-003 Parameter MAN_COLOUR, default 3'b111, is the sprite colour when man_style=1; GHOST_COLOUR, default 3'b011, is the colour when man_style=0.
REQ-004 Parameter BG_COLOUR, default 3'b000, is the erase colour.
REQ-005 clk  input  1  system clock; all logic is rising-edge.
REQ-006 resetn  input  1  reset: asynchronous, active-low.
REQ-007 update  input  1  one-cycle redraw strobe, synchronous to clk.
REQ-008 y  input  7  sprite top row, taken from the vertical-position stage.
REQ-009 man_style  input  1  colour select.
REQ-010 plot  output  1  pixel write enable to the VGA adapter.
REQ-011 vga_x  output  8  pixel column.
REQ-012 vga_y  output  7  pixel row.
REQ-013 colour  output  3  pixel colour.
REQ-014 busy  output  1  high from update acceptance until the last pass cycle.
REQ-015 frame_done  output  1  one-cycle pulse after the final draw pixel.

Function
REQ-016 The FSM has states IDLE, ERASE, DRAW and FIN; it leaves reset in IDLE.
REQ-017 In IDLE, update (or a pending flag) captures y into y_cap and man_style into style_cap, and the FSM moves to ERASE the next cycle.
REQ-018 ERASE is skipped, with a direct move to DRAW, when old_valid=0 or y_cap==old_y.
REQ-019 Each pass scans row 0..SPR_H-1 (outer) and col 0..SPR_W-1 (inner), one pixel per cycle, SPR_W*SPR_H cycles (96 by default) with no gaps.
REQ-020 ERASE pixels are vga_x=X_POS+col, vga_y=old_y+row, colour=BG_COLOUR.
REQ-021 DRAW pixels are vga_x=X_POS+col, vga_y=y_cap+row, colour=style_cap?MAN_COLOUR:GHOST_COLOUR.
REQ-022 plot, vga_x, vga_y and colour are registered and valid in the same cycle; plot=0 outside ERASE/DRAW.
REQ-023 Row sums are computed 8 bits wide; a pixel whose row sum is >119 has plot=0, but its cycle is still consumed (fixed pass length).
REQ-024 After the last DRAW pixel the FSM enters FIN for one cycle: frame_done=1, old_y<=y_cap, old_valid<=1, then IDLE.
REQ-025 First plot latency is 1 cycle after the capture cycle (capture at t, first pixel at t+1).
REQ-026 busy=1 from the cycle after capture through FIN inclusive.
REQ-027 update while not IDLE sets a one-deep pending flag; further updates while pending are absorbed (no queue growth).
REQ-028 Pending is served on the IDLE cycle following FIN using the y value at that cycle, then cleared.
REQ-029 update coinciding with the FIN cycle sets pending.
REQ-030 y and man_style changes during a pass have no effect on that pass.

Reset
REQ-031 resetn=0 forces immediately: state=IDLE, plot=0, vga_x=0, vga_y=0, colour=0, busy=0, frame_done=0, pending=0, old_valid=0, old_y=7'd108, counters=0.
REQ-032 A reset mid-pass aborts with no further plots; the next pass performs no erase.

Verification
REQ-033 Reset, then update with y=108, man_style=1 -> no erase; 96 plots covering x 20..27, y 108..119, colour 111; frame_done pulses one cycle after the last plot; busy then low.
REQ-034 After REQ-033, update with y=99 -> 96 plots at y 108..119 with colour 000, then 96 plots at y 99..110 with colour 111; 192 consecutive plot cycles.
REQ-035 Update with y equal to old_y and man_style=0 -> erase skipped; 96 plots with colour 011.
REQ-036 Three updates during a pass -> exactly one additional pass begins on the IDLE cycle after FIN, using y at that cycle.
REQ-037 Update with y=115 -> draw pass lasts 96 cycles, 40 plots at rows 115..119, and plot=0 for rows 120..126.
REQ-038 resetn pulsed at pixel 50 of DRAW -> plot and busy drop asynchronously; the following update with y=60 gives 96 draw plots and no erase.
